// File: rtl/banyan_pkg.sv
// Shared definitions for the banyan capture memory control path.
// Holds the acquisition state encoding and the default lane address width.
package banyan_pkg;

  localparam int unsigned DefaultAw = 12;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StPre   = 3'd2,
    StArmed = 3'd3,
    StPost  = 3'd4,
    StDone  = 3'd5
  } acq_state_e;

endpackage

// File: rtl/banyan_acq_ctl.sv
// Acquisition sequencer: turns start/stop/trigger into banyan memory reset/run controls,
// enforcing pre-trigger history and post-trigger length, and records the trigger pointer.
module banyan_acq_ctl
  import banyan_pkg::*;
#(
  parameter int unsigned Aw = DefaultAw,
  parameter int unsigned Pw = Aw + 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          trig_i,
  input  logic          trig_en_i,
  input  logic [Pw-1:0] pre_count_i,
  input  logic [Pw-1:0] post_count_i,
  input  logic [Pw-1:0] mem_pointer_i,
  input  logic          mem_rollover_i,
  input  logic          mem_full_i,
  output logic          mem_reset_o,
  output logic          mem_run_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          wrapped_o,
  output logic [Pw-1:0] trig_ptr_o,
  output logic [2:0]    state_o
);

  acq_state_e    state_q, state_d;
  logic [Pw-1:0] cnt_q, cnt_d;
  logic [Pw-1:0] pre_q, pre_d;
  logic [Pw-1:0] post_q, post_d;
  logic [Pw-1:0] trig_ptr_q, trig_ptr_d;
  logic          wrapped_q, wrapped_d;
  logic          start_ok;
  logic          running;

  // Full flag is informational only; the sequencer never reacts to it.
  logic unused_mem_full;
  assign unused_mem_full = mem_full_i;

  assign start_ok = start_i & ~stop_i;
  assign running  = (state_q == StPre) || (state_q == StArmed) || (state_q == StPost);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    post_d     = post_q;
    trig_ptr_d = trig_ptr_q;
    wrapped_d  = wrapped_q;

    if (running && mem_rollover_i) begin
      wrapped_d = 1'b1;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          state_d    = StClear;
          pre_d      = pre_count_i;
          post_d     = post_count_i;
          wrapped_d  = 1'b0;
          trig_ptr_d = '0;
        end
      end
      StClear: begin
        cnt_d   = '0;
        state_d = (pre_q == '0) ? StArmed : StPre;
      end
      StPre: begin
        // Compare against count-1 so a full-scale count never overflows the counter.
        if (cnt_q == pre_q - Pw'(1)) begin
          cnt_d   = '0;
          state_d = StArmed;
        end else begin
          cnt_d = cnt_q + Pw'(1);
        end
      end
      StArmed: begin
        if (trig_i && trig_en_i) begin
          trig_ptr_d = mem_pointer_i;
          cnt_d      = '0;
          state_d    = (post_q == '0) ? StDone : StPost;
        end
      end
      StPost: begin
        if (cnt_q == post_q - Pw'(1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + Pw'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (stop_i) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pre_q      <= '0;
      post_q     <= '0;
      trig_ptr_q <= '0;
      wrapped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      post_q     <= post_d;
      trig_ptr_q <= trig_ptr_d;
      wrapped_q  <= wrapped_d;
    end
  end

  // All outputs decode directly from registered state, so none has an input-to-output path.
  assign mem_reset_o = (state_q == StClear);
  assign mem_run_o   = running;
  assign busy_o      = (state_q != StIdle) && (state_q != StDone);
  assign done_o      = (state_q == StDone);
  assign wrapped_o   = wrapped_q;
  assign trig_ptr_o  = trig_ptr_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_banyan_acq_ctl.sv
// Directed self-checking bench for banyan_acq_ctl, with a small write-pointer memory model.
module tb_banyan_acq_ctl;

  localparam int unsigned Aw = 4;
  localparam int unsigned Pw = Aw + 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i, stop_i, trig_i, trig_en_i;
  logic [Pw-1:0] pre_count_i, post_count_i;
  logic [Pw-1:0] mem_pointer_i = '0;
  logic          mem_rollover_i, mem_full_i;
  logic          mem_reset_o, mem_run_o, busy_o, done_o, wrapped_o;
  logic [Pw-1:0] trig_ptr_o;
  logic [2:0]    state_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  // Memory model: pointer clears on reset pulse, advances while running, pulses on wrap.
  always_ff @(posedge clk_i) begin
    if (mem_reset_o) mem_pointer_i <= '0;
    else if (mem_run_o) mem_pointer_i <= mem_pointer_i + Pw'(1);
  end
  assign mem_rollover_i = mem_run_o && (mem_pointer_i == {Pw{1'b1}});
  assign mem_full_i     = mem_pointer_i[Pw-1];

  banyan_acq_ctl #(.Aw(Aw), .Pw(Pw)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .trig_i        (trig_i),
    .trig_en_i     (trig_en_i),
    .pre_count_i   (pre_count_i),
    .post_count_i  (post_count_i),
    .mem_pointer_i (mem_pointer_i),
    .mem_rollover_i(mem_rollover_i),
    .mem_full_i    (mem_full_i),
    .mem_reset_o   (mem_reset_o),
    .mem_run_o     (mem_run_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .wrapped_o     (wrapped_o),
    .trig_ptr_o    (trig_ptr_o),
    .state_o       (state_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_stop();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    start_i = 0; stop_i = 0; trig_i = 0; trig_en_i = 0;
    pre_count_i = '0; post_count_i = '0;
    tick(); tick();
    checks++;
    if ({state_o, mem_reset_o, mem_run_o, busy_o, done_o, wrapped_o, trig_ptr_o} !== '0) begin
      failures++;
      $display("FAIL reset_state: state=%0d outs=%b trig_ptr=%0d, want all 0", state_o,
               {mem_reset_o, mem_run_o, busy_o, done_o, wrapped_o}, trig_ptr_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int runs = 0, resets = 0, armed = 0, gaps = 0;
    logic saw_done = 1'b0;
    pre_count_i = 7'd8; post_count_i = 7'd16; trig_i = 0; trig_en_i = 1;
    start_i = 1; tick(); start_i = 0;
    checks++;
    if (state_o !== 3'd1 || mem_reset_o !== 1'b1 || mem_run_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_clear: state=%0d reset=%b run=%b, want 1/1/0", state_o,
               mem_reset_o, mem_run_o);
    end
    for (int i = 0; i < 200 && !saw_done; i++) begin
      tick();
      trig_i = 0;
      if (mem_run_o) runs++;
      else if (runs > 0 && !done_o) gaps++;
      if (mem_reset_o) resets++;
      if (state_o == 3'd3) begin
        armed++;
        if (armed == 20) trig_i = 1;
      end
      if (done_o) saw_done = 1'b1;
    end
    checks++;
    if (!saw_done || state_o !== 3'd5 || busy_o !== 1'b0 || mem_run_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: state=%0d busy=%b run=%b, want 5/0/0", state_o, busy_o,
               mem_run_o);
    end
    checks++;
    if (runs !== 44 || gaps !== 0 || resets !== 0) begin
      failures++;
      $display("FAIL basic_run_len: runs=%0d gaps=%0d resets=%0d, want 44/0/0", runs, gaps,
               resets);
    end
    checks++;
    if (trig_ptr_o !== 7'd27) begin
      failures++;
      $display("FAIL basic_trig_ptr: got %0d, want 27", trig_ptr_o);
    end
    do_stop();
  endtask

  task automatic test_trig_timing();
    logic [2:0] exp_seq [7] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4};
    pre_count_i = 7'd4; post_count_i = 7'd2; trig_i = 1; trig_en_i = 1;
    start_i = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      start_i = 0;
      checks++;
      if (state_o !== exp_seq[i]) begin
        failures++;
        $display("FAIL trig_timing_seq[%0d]: state=%0d, want %0d", i, state_o, exp_seq[i]);
      end
    end
    do_stop();
    trig_en_i = 0;
    start_i = 1; tick(); start_i = 0;
    for (int i = 0; i < 50; i++) tick();
    checks++;
    if (state_o !== 3'd3 || mem_run_o !== 1'b1) begin
      failures++;
      $display("FAIL trig_en_gate: state=%0d run=%b, want 3/1", state_o, mem_run_o);
    end
    trig_i = 0; trig_en_i = 1;
    do_stop();
  endtask

  task automatic test_zero_counts();
    pre_count_i = '0; post_count_i = '0; trig_i = 0; trig_en_i = 1;
    start_i = 1; tick(); start_i = 0;
    tick();
    checks++;
    if (state_o !== 3'd3 || mem_run_o !== 1'b1) begin
      failures++;
      $display("FAIL zero_clear_to_armed: state=%0d run=%b, want 3/1", state_o, mem_run_o);
    end
    trig_i = 1; tick(); trig_i = 0;
    checks++;
    if (state_o !== 3'd5 || mem_run_o !== 1'b0 || done_o !== 1'b1 || trig_ptr_o !== 7'd0) begin
      failures++;
      $display("FAIL zero_armed_to_done: state=%0d run=%b done=%b ptr=%0d, want 5/0/1/0",
               state_o, mem_run_o, done_o, trig_ptr_o);
    end
    do_stop();
  endtask

  task automatic test_wrap();
    pre_count_i = 7'd2; post_count_i = 7'd2; trig_i = 0; trig_en_i = 1;
    start_i = 1; tick(); start_i = 0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (wrapped_o !== 1'b0) begin
      failures++;
      $display("FAIL wrap_early: wrapped=%b, want 0", wrapped_o);
    end
    for (int i = 0; i < 200; i++) tick();
    checks++;
    if (wrapped_o !== 1'b1 || state_o !== 3'd3) begin
      failures++;
      $display("FAIL wrap_set: wrapped=%b state=%0d, want 1/3", wrapped_o, state_o);
    end
    do_stop();
    checks++;
    if (wrapped_o !== 1'b1 || state_o !== 3'd0) begin
      failures++;
      $display("FAIL wrap_sticky: wrapped=%b state=%0d, want 1/0", wrapped_o, state_o);
    end
    start_i = 1; tick(); start_i = 0;
    checks++;
    if (wrapped_o !== 1'b0 || state_o !== 3'd1) begin
      failures++;
      $display("FAIL wrap_clear_on_start: wrapped=%b state=%0d, want 0/1", wrapped_o, state_o);
    end
    do_stop();
  endtask

  task automatic test_abort();
    pre_count_i = 7'd1; post_count_i = 7'd10; trig_i = 1; trig_en_i = 1;
    start_i = 1; tick(); start_i = 0;
    tick(); tick(); tick();
    trig_i = 0;
    checks++;
    if (state_o !== 3'd4) begin
      failures++;
      $display("FAIL abort_reach_post: state=%0d, want 4", state_o);
    end
    do_stop();
    checks++;
    if (state_o !== 3'd0 || mem_run_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_stop: state=%0d run=%b busy=%b, want 0/0/0", state_o, mem_run_o,
               busy_o);
    end
    start_i = 1; stop_i = 1; tick(); start_i = 0; stop_i = 0;
    checks++;
    if (state_o !== 3'd0 || mem_reset_o !== 1'b0) begin
      failures++;
      $display("FAIL start_stop_collide: state=%0d reset=%b, want 0/0", state_o, mem_reset_o);
    end
    pre_count_i = '0;
    start_i = 1; tick(); start_i = 0;
    tick();
    start_i = 1; tick(); start_i = 0;
    checks++;
    if (state_o !== 3'd3 || mem_reset_o !== 1'b0 || mem_run_o !== 1'b1) begin
      failures++;
      $display("FAIL start_while_busy: state=%0d reset=%b run=%b, want 3/0/1", state_o,
               mem_reset_o, mem_run_o);
    end
    do_stop();
  endtask

  task automatic test_reset_mid();
    int runs = 0;
    logic saw_done = 1'b0;
    pre_count_i = 7'd1; post_count_i = 7'd10; trig_i = 1; trig_en_i = 1;
    start_i = 1; tick(); start_i = 0;
    tick(); tick(); tick();
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    checks++;
    if ({state_o, mem_reset_o, mem_run_o, busy_o, done_o, wrapped_o, trig_ptr_o} !== '0) begin
      failures++;
      $display("FAIL reset_mid_post: state=%0d outs=%b trig_ptr=%0d, want all 0", state_o,
               {mem_reset_o, mem_run_o, busy_o, done_o, wrapped_o}, trig_ptr_o);
    end
    pre_count_i = 7'd3; post_count_i = 7'd3;
    start_i = 1; tick(); start_i = 0;
    for (int i = 0; i < 50 && !saw_done; i++) begin
      tick();
      if (mem_run_o) runs++;
      if (done_o) saw_done = 1'b1;
    end
    checks++;
    if (!saw_done || runs !== 7 || trig_ptr_o !== 7'd3) begin
      failures++;
      $display("FAIL reset_then_capture: done=%b runs=%0d ptr=%0d, want 1/7/3", saw_done, runs,
               trig_ptr_o);
    end
    trig_i = 0;
    do_stop();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trig_timing();
    test_zero_counts();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
